// File: rtl/tx_ctrl_pkg.sv
// Shared definitions for the C-PHY transmit LP control sequencer: state set,
// LP line codes (also consumed by the receive-side decoder) and code lookup.
package tx_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_STOP       = 4'd0,
    ST_HS_RQST    = 4'd1,
    ST_HS_PREP    = 4'd2,
    ST_HS_GO      = 4'd3,
    ST_ESC_RQST   = 4'd4,
    ST_ESC_BRIDGE = 4'd5,
    ST_ESC_ENTRY  = 4'd6,
    ST_ESC_GO     = 4'd7,
    ST_ESC_EXIT   = 4'd8,
    ST_TA_RQST    = 4'd9,
    ST_TA_BRIDGE  = 4'd10,
    ST_TA_YIELD   = 4'd11,
    ST_TA_GET     = 4'd12,
    ST_TA_HIZ     = 4'd13
  } tx_state_e;

  localparam logic [2:0] LP_STOP    = 3'b111;
  localparam logic [2:0] LP_HS_RQST = 3'b001;
  localparam logic [2:0] LP_BRIDGE  = 3'b000;
  localparam logic [2:0] LP_LP_RQST = 3'b100;

  // A/B/C levels driven in each state; TA_HIZ keeps the bridge level behind a released driver.
  function automatic logic [2:0] lp_code(input tx_state_e st);
    logic [2:0] code;
    case (st)
      ST_STOP:       code = LP_STOP;
      ST_HS_RQST:    code = LP_HS_RQST;
      ST_HS_PREP:    code = LP_BRIDGE;
      ST_HS_GO:      code = LP_BRIDGE;
      ST_ESC_RQST:   code = LP_LP_RQST;
      ST_ESC_BRIDGE: code = LP_BRIDGE;
      ST_ESC_ENTRY:  code = LP_HS_RQST;
      ST_ESC_GO:     code = LP_BRIDGE;
      ST_ESC_EXIT:   code = LP_LP_RQST;
      ST_TA_RQST:    code = LP_LP_RQST;
      ST_TA_BRIDGE:  code = LP_BRIDGE;
      ST_TA_YIELD:   code = LP_LP_RQST;
      ST_TA_GET:     code = LP_BRIDGE;
      ST_TA_HIZ:     code = LP_BRIDGE;
      default:       code = LP_STOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tx_ctrl_timer.sv
// Load/decrement duration counter; done is high while the count sits at zero.
module tx_ctrl_timer
  import tx_ctrl_pkg::*;
#(
  parameter int                 CNT_W   = 8,
  parameter logic [CNT_W-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;

  // Counter: load wins, otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= RST_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/tx_ctrl_sequencer.sv
// C-PHY master-lane LP control sequencer: timed HS entry, escape entry and
// bus turnaround sequences on A/B/C, with registered handoff flags.
module tx_ctrl_sequencer
  import tx_ctrl_pkg::*;
#(
  parameter int T_LPX     = 4,
  parameter int T_HS_PREP = 6,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic CtrlEncEn,
  input  logic HsReq,
  input  logic EscReq,
  input  logic TaReq,
  output logic A,
  output logic B,
  output logic C,
  output logic LpOe,
  output logic HsReady,
  output logic EscReady,
  output logic TaDone,
  output logic Busy
);

  localparam logic [CNT_W-1:0] LPX_LOAD  = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0] PREP_LOAD = CNT_W'(T_HS_PREP - 1);

  tx_state_e        state_r;
  tx_state_e        next_s;
  logic             tmr_load_s;
  logic [CNT_W-1:0] tmr_val_s;
  logic             tmr_done_s;

  tx_ctrl_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LPX_LOAD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // Next-state selection; in STOP the timer doubles as the minimum-hold guard.
  always_comb begin
    next_s = state_r;
    if (!CtrlEncEn) begin
      next_s = ST_STOP;
    end else begin
      case (state_r)
        ST_STOP: begin
          if (tmr_done_s && HsReq)       next_s = ST_HS_RQST;
          else if (tmr_done_s && TaReq)  next_s = ST_TA_RQST;
          else if (tmr_done_s && EscReq) next_s = ST_ESC_RQST;
          else                           next_s = ST_STOP;
        end
        ST_HS_RQST:    next_s = tmr_done_s ? ST_HS_PREP    : state_r;
        ST_HS_PREP:    next_s = tmr_done_s ? ST_HS_GO      : state_r;
        ST_HS_GO:      next_s = HsReq      ? ST_HS_GO      : ST_STOP;
        ST_ESC_RQST:   next_s = tmr_done_s ? ST_ESC_BRIDGE : state_r;
        ST_ESC_BRIDGE: next_s = tmr_done_s ? ST_ESC_ENTRY  : state_r;
        ST_ESC_ENTRY:  next_s = tmr_done_s ? ST_ESC_GO     : state_r;
        ST_ESC_GO:     next_s = EscReq     ? ST_ESC_GO     : ST_ESC_EXIT;
        ST_ESC_EXIT:   next_s = tmr_done_s ? ST_STOP       : state_r;
        ST_TA_RQST:    next_s = tmr_done_s ? ST_TA_BRIDGE  : state_r;
        ST_TA_BRIDGE:  next_s = tmr_done_s ? ST_TA_YIELD   : state_r;
        ST_TA_YIELD:   next_s = tmr_done_s ? ST_TA_GET     : state_r;
        ST_TA_GET:     next_s = tmr_done_s ? ST_TA_HIZ     : state_r;
        ST_TA_HIZ:     next_s = TaReq      ? ST_TA_HIZ     : ST_STOP;
        default:       next_s = ST_STOP;
      endcase
    end
  end

  // Timer reload on every state entry, and continuously while disabled so the STOP hold restarts.
  always_comb begin
    tmr_load_s = (next_s != state_r) || !CtrlEncEn;
    case (next_s)
      ST_HS_PREP: tmr_val_s = PREP_LOAD;
      ST_HS_GO:   tmr_val_s = {CNT_W{1'b0}};
      ST_ESC_GO:  tmr_val_s = {CNT_W{1'b0}};
      ST_TA_HIZ:  tmr_val_s = {CNT_W{1'b0}};
      default:    tmr_val_s = LPX_LOAD;
    endcase
  end

  // State and outputs, all decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_STOP;
      {A, B, C} <= LP_STOP;
      LpOe      <= 1'b1;
      HsReady   <= 1'b0;
      EscReady  <= 1'b0;
      TaDone    <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state_r   <= next_s;
      {A, B, C} <= lp_code(next_s);
      LpOe      <= (next_s != ST_TA_HIZ);
      HsReady   <= (next_s == ST_HS_GO);
      EscReady  <= (next_s == ST_ESC_GO);
      TaDone    <= (next_s == ST_TA_HIZ) && (state_r != ST_TA_HIZ);
      Busy      <= (next_s != ST_STOP);
    end
  end

endmodule
